// File: rtl/mem_pkg.sv
// MEM stage shared definitions: EX_MEM / MEM_WB bit offsets, MemtoReg codes, access FSM states.
// No logic; imported by the MEM stage top and its access controller.
// Field offsets are the single source of truth for both pipeline bundles.
package mem_pkg;

    // EX_MEM bundle field map
    localparam int EXM_WIDTH        = 73;
    localparam int EXM_WDATA_LSB    = 0;
    localparam int EXM_ALU_LSB      = 32;
    localparam int EXM_WREG_LSB     = 64;
    localparam int EXM_MEMWRITE     = 69;
    localparam int EXM_REGWRITE     = 70;
    localparam int EXM_MEMTOREG_LSB = 71;

    // MEM_WB bundle field map
    localparam int MWB_WIDTH        = 72;
    localparam int MWB_ALU_LSB      = 0;
    localparam int MWB_RDATA_LSB    = 32;
    localparam int MWB_WREG_LSB     = 64;
    localparam int MWB_REGWRITE     = 69;
    localparam int MWB_MEMTOREG_LSB = 70;

    // MemtoReg encodings; 1x is reserved and behaves like ALU
    localparam logic [1:0] MTR_ALU = 2'b00;
    localparam logic [1:0] MTR_MEM = 2'b01;

    // Data-memory access FSM
    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } accState_e;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/ready bus between the MEM stage (master) and the data memory (slave).
// Combinational wires only, no latency of its own.
// mem_ready completes the outstanding request; the master holds mem_req until then.
interface mem_stage_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/mem_access_ctl.sv
// Data-memory access controller: IDLE/BUSY FSM, wait counter, request/stall/error generation.
// Request is raised in the same cycle the access appears; zero-wait completion costs no stall.
// Stalls upstream until mem_ready, or abandons the access after TIMEOUT BUSY cycles.
module mem_access_ctl
    import mem_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic access,
    input  logic misaligned,
    input  logic memReady,
    output logic memReq,
    output logic memStall,
    output logic memErr,
    output logic memDone
);

    accState_e  state;
    logic [4:0] cnt;
    logic       issue;
    logic       timeout;

    // Request/stall/error decode; everything is forced low while in reset so the
    // memory side sees an abandoned request drop immediately.
    always_comb begin
        issue    = (state == S_IDLE) && access && !misaligned;
        timeout  = (state == S_BUSY) && (cnt == 5'(TIMEOUT - 1)) && !memReady;
        memReq   = !rst && (issue || (state == S_BUSY));
        memDone  = memReq && memReady;
        memStall = !rst && ((issue && !memReady) ||
                            ((state == S_BUSY) && !memReady && !timeout));
        memErr   = !rst && (((state == S_IDLE) && access && misaligned) || timeout);
    end

    // FSM and wait counter: enter BUSY only when the memory did not answer in the issue cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (issue && !memReady) begin
                        state <= S_BUSY;
                        cnt   <= '0;
                    end
                end
                S_BUSY: begin
                    if (memReady || timeout) begin
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: load/store over the data-memory bus, MEM-side forwarding, MEM_WB register.
// One cycle to MEM_WB with a zero-wait memory; each wait cycle inserts one MEM_WB bubble.
// MEM_Stall freezes PC..EX_MEM while an access is outstanding; forwarding stays valid meanwhile.
module mem_stage
    import mem_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [EXM_WIDTH-1:0] EX_MEM,
    mem_stage_if.master          memBus,
    output logic                 MEM_Stall,
    output logic                 MEM_Err,
    output logic                 MEM_RegWrite,
    output logic [4:0]           MEM_WriteRegister,
    output logic [31:0]          MEM_RegWriteData,
    output logic [MWB_WIDTH-1:0] MEM_WB
);

    logic [31:0] writeData;
    logic [31:0] aluResult;
    logic [4:0]  writeReg;
    logic        memWrite;
    logic        regWrite;
    logic [1:0]  memtoReg;
    logic        isLoad;
    logic        access;
    logic        misaligned;
    logic        memReq;
    logic        memDone;
    logic [31:0] readData;

    // EX_MEM field decode and access classification
    always_comb begin
        writeData  = EX_MEM[EXM_WDATA_LSB +: 32];
        aluResult  = EX_MEM[EXM_ALU_LSB +: 32];
        writeReg   = EX_MEM[EXM_WREG_LSB +: 5];
        memWrite   = EX_MEM[EXM_MEMWRITE];
        regWrite   = EX_MEM[EXM_REGWRITE];
        memtoReg   = EX_MEM[EXM_MEMTOREG_LSB +: 2];
        isLoad     = (memtoReg == MTR_MEM) && !memWrite;
        access     = memWrite || (memtoReg == MTR_MEM);
        misaligned = (aluResult[1:0] != 2'b00);
        // Only a load that the memory actually completed returns data; timeouts,
        // misaligned accesses and stores all write back zero.
        readData   = (isLoad && memDone) ? memBus.mem_rdata : 32'h0;
    end

    mem_access_ctl #(
        .TIMEOUT (TIMEOUT)
    ) u_ctl (
        .clk        (clk),
        .rst        (rst),
        .access     (access),
        .misaligned (misaligned),
        .memReady   (memBus.mem_ready),
        .memReq     (memReq),
        .memStall   (MEM_Stall),
        .memErr     (MEM_Err),
        .memDone    (memDone)
    );

    assign memBus.mem_req   = memReq;
    assign memBus.mem_we    = memReq && memWrite;
    assign memBus.mem_addr  = aluResult;
    assign memBus.mem_wdata = writeData;

    // For loads this forwards the address; the ID hazard unit owns the load-use bubble.
    assign MEM_RegWrite      = regWrite;
    assign MEM_WriteRegister = writeReg;
    assign MEM_RegWriteData  = aluResult;

    // MEM_WB: bubble while stalled, otherwise capture the instruction leaving MEM.
    always_ff @(posedge clk) begin
        if (rst || MEM_Stall) begin
            MEM_WB <= '0;
        end else begin
            MEM_WB <= {memtoReg, regWrite, writeReg, readData, aluResult};
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, zero-wait and wait-state accesses,
// timeout abandonment, misaligned access, reserved MemtoReg and reset during an access.
// Inputs change 1 ns after posedge; outputs are sampled 1 ns later, well clear of the edge.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [72:0] exMem = '0;
    logic        stall;
    logic        err;
    logic        fwdRegWrite;
    logic [4:0]  fwdWriteReg;
    logic [31:0] fwdData;
    logic [71:0] memWb;

    int tests = 0;
    int fails = 0;

    mem_stage_if bus ();

    mem_stage #(.TIMEOUT(16)) dut (
        .clk               (clk),
        .rst               (rst),
        .EX_MEM            (exMem),
        .memBus            (bus),
        .MEM_Stall         (stall),
        .MEM_Err           (err),
        .MEM_RegWrite      (fwdRegWrite),
        .MEM_WriteRegister (fwdWriteReg),
        .MEM_RegWriteData  (fwdData),
        .MEM_WB            (memWb)
    );

    always #5 clk = ~clk;

    function automatic logic [72:0] mkEx(input logic [1:0] mtr, input logic rw, input logic mw,
                                         input logic [4:0] wr, input logic [31:0] alu,
                                         input logic [31:0] wd);
        return {mtr, rw, mw, wr, alu, wd};
    endfunction

    function automatic logic [71:0] mkWb(input logic [1:0] mtr, input logic rw, input logic [4:0] wr,
                                         input logic [31:0] rd, input logic [31:0] alu);
        return {mtr, rw, wr, rd, alu};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [71:0] exp = '0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'h0;
        rst   = 1'b1;
        exMem = mkEx(2'b01, 1'b1, 1'b0, 5'd2, 32'h0000_0010, 32'h0);
        tick();
        tick();
        #1;
        tests++; if (memWb !== exp) begin fails++; $display("FAIL reset_memwb: got %h want %h", memWb, exp); end
        tests++; if (bus.mem_req !== 1'b0) begin fails++; $display("FAIL reset_req: got %b want 0", bus.mem_req); end
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b want 0", stall); end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", err); end
        tick();
        rst   = 1'b0;
        exMem = '0;
        tick();
    endtask

    task automatic test_alu();
        logic [71:0] exp = mkWb(2'b00, 1'b1, 5'd5, 32'h0, 32'h0000_1234);
        exMem = mkEx(2'b00, 1'b1, 1'b0, 5'd5, 32'h0000_1234, 32'h0000_0055);
        #1;
        tests++; if (bus.mem_req !== 1'b0 || stall !== 1'b0 || err !== 1'b0) begin
            fails++; $display("FAIL alu_ctl: got req=%b stall=%b err=%b want 0/0/0", bus.mem_req, stall, err); end
        tests++; if ({fwdRegWrite, fwdWriteReg, fwdData} !== {1'b1, 5'd5, 32'h0000_1234}) begin
            fails++; $display("FAIL alu_fwd: got %b/%0d/%h want 1/5/00001234", fwdRegWrite, fwdWriteReg, fwdData); end
        tick();
        tests++; if (memWb !== exp) begin fails++; $display("FAIL alu_memwb: got %h want %h", memWb, exp); end
    endtask

    task automatic test_store_zero_wait();
        logic [71:0] exp = mkWb(2'b00, 1'b0, 5'd0, 32'h0, 32'h0000_0040);
        exMem = mkEx(2'b00, 1'b0, 1'b1, 5'd0, 32'h0000_0040, 32'h0000_DEAD);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h5555_5555;
        #1;
        tests++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1) begin
            fails++; $display("FAIL store_req: got req=%b we=%b want 1/1", bus.mem_req, bus.mem_we); end
        tests++; if (bus.mem_addr !== 32'h40 || bus.mem_wdata !== 32'hDEAD) begin
            fails++; $display("FAIL store_bus: got addr=%h wdata=%h want 40/dead", bus.mem_addr, bus.mem_wdata); end
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL store_stall: got %b want 0", stall); end
        tick();
        exMem = '0;
        bus.mem_ready = 1'b0;
        #1;
        tests++; if (bus.mem_req !== 1'b0 || stall !== 1'b0) begin
            fails++; $display("FAIL store_after: got req=%b stall=%b want 0/0", bus.mem_req, stall); end
        tests++; if (memWb !== exp) begin fails++; $display("FAIL store_memwb: got %h want %h", memWb, exp); end
        tick();
    endtask

    task automatic test_load_wait();
        logic [71:0] exp = mkWb(2'b01, 1'b1, 5'd9, 32'h0000_CAFE, 32'h0000_0080);
        // leave a non-zero MEM_WB behind so the bubbles are visible
        exMem = mkEx(2'b00, 1'b1, 1'b0, 5'd1, 32'h0000_0777, 32'h0);
        tick();
        exMem = mkEx(2'b01, 1'b1, 1'b0, 5'd9, 32'h0000_0080, 32'h0);
        for (int i = 0; i < 4; i++) begin
            bus.mem_ready = (i == 3);
            bus.mem_rdata = (i == 3) ? 32'h0000_CAFE : 32'hFFFF_FFFF;
            #1;
            tests++; if (stall !== (i < 3)) begin
                fails++; $display("FAIL load_stall_c%0d: got %b want %b", i, stall, (i < 3)); end
            tests++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0) begin
                fails++; $display("FAIL load_req_c%0d: got req=%b we=%b want 1/0", i, bus.mem_req, bus.mem_we); end
            tick();
            if (i < 3) begin
                tests++; if (memWb !== 72'h0) begin
                    fails++; $display("FAIL load_bubble_c%0d: got %h want 0", i, memWb); end
            end
        end
        bus.mem_ready = 1'b0;
        exMem = '0;
        #1;
        tests++; if (memWb !== exp) begin fails++; $display("FAIL load_memwb: got %h want %h", memWb, exp); end
        tests++; if (bus.mem_req !== 1'b0) begin fails++; $display("FAIL load_idle: got req=%b want 0", bus.mem_req); end
        tick();
    endtask

    task automatic test_timeout();
        logic [71:0] exp = mkWb(2'b01, 1'b1, 5'd3, 32'h0, 32'h0000_0100);
        int stallCount = 0;
        int errCount = 0;
        exMem = mkEx(2'b01, 1'b1, 1'b0, 5'd3, 32'h0000_0100, 32'h0);
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'hBAD0_BAD0;
        // issue cycle + 15 stalled BUSY cycles, abandoned in the 16th BUSY cycle
        for (int c = 0; c <= 16; c++) begin
            #1;
            if (stall === 1'b1) stallCount++;
            if (err === 1'b1) errCount++;
            if (c == 16) begin
                tests++; if (stall !== 1'b0 || err !== 1'b1 || bus.mem_req !== 1'b1) begin
                    fails++; $display("FAIL timeout_last: got stall=%b err=%b req=%b want 0/1/1", stall, err, bus.mem_req); end
            end
            tick();
        end
        tests++; if (stallCount != 16) begin fails++; $display("FAIL timeout_stalls: got %0d want 16", stallCount); end
        tests++; if (errCount != 1) begin fails++; $display("FAIL timeout_errs: got %0d want 1", errCount); end
        exMem = '0;
        #1;
        tests++; if (memWb !== exp) begin fails++; $display("FAIL timeout_memwb: got %h want %h", memWb, exp); end
        tests++; if (err !== 1'b0 || bus.mem_req !== 1'b0) begin
            fails++; $display("FAIL timeout_after: got err=%b req=%b want 0/0", err, bus.mem_req); end
        tick();
    endtask

    task automatic test_misaligned();
        logic [71:0] exp = mkWb(2'b01, 1'b1, 5'd7, 32'h0, 32'h0000_0082);
        exMem = mkEx(2'b01, 1'b1, 1'b0, 5'd7, 32'h0000_0082, 32'h0);
        bus.mem_ready = 1'b1;   // must be ignored: no request is outstanding
        bus.mem_rdata = 32'h1111_1111;
        #1;
        tests++; if (bus.mem_req !== 1'b0 || stall !== 1'b0 || err !== 1'b1) begin
            fails++; $display("FAIL misaligned_ctl: got req=%b stall=%b err=%b want 0/0/1", bus.mem_req, stall, err); end
        tick();
        exMem = '0;
        bus.mem_ready = 1'b0;
        #1;
        tests++; if (memWb !== exp) begin fails++; $display("FAIL misaligned_memwb: got %h want %h", memWb, exp); end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL misaligned_pulse: got %b want 0", err); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [71:0] expA = mkWb(2'b10, 1'b1, 5'd11, 32'h0, 32'h0000_0ABC);
        logic [71:0] expB = mkWb(2'b01, 1'b1, 5'd12, 32'h0000_BEEF, 32'h0000_0044);
        // reserved MemtoReg=10 is a plain ALU pass, no memory access
        exMem = mkEx(2'b10, 1'b1, 1'b0, 5'd11, 32'h0000_0ABC, 32'h0);
        #1;
        tests++; if (bus.mem_req !== 1'b0) begin fails++; $display("FAIL b2b_reserved_req: got %b want 0", bus.mem_req); end
        tick();
        exMem = mkEx(2'b01, 1'b1, 1'b0, 5'd12, 32'h0000_0044, 32'h0);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h0000_BEEF;
        #1;
        tests++; if (memWb !== expA) begin fails++; $display("FAIL b2b_first: got %h want %h", memWb, expA); end
        tests++; if (stall !== 1'b0 || bus.mem_req !== 1'b1) begin
            fails++; $display("FAIL b2b_load_ctl: got stall=%b req=%b want 0/1", stall, bus.mem_req); end
        tick();
        exMem = '0;
        bus.mem_ready = 1'b0;
        #1;
        tests++; if (memWb !== expB) begin fails++; $display("FAIL b2b_second: got %h want %h", memWb, expB); end
        tick();
    endtask

    task automatic test_reset_mid_access();
        exMem = mkEx(2'b01, 1'b1, 1'b0, 5'd4, 32'h0000_0200, 32'h0);
        bus.mem_ready = 1'b0;
        tick();     // issue cycle -> BUSY
        tick();     // BUSY cycle 1
        rst = 1'b1; // BUSY cycle 2
        #1;
        tests++; if (bus.mem_req !== 1'b0 || stall !== 1'b0 || err !== 1'b0) begin
            fails++; $display("FAIL rstmid_gate: got req=%b stall=%b err=%b want 0/0/0", bus.mem_req, stall, err); end
        tick();
        rst   = 1'b0;
        exMem = '0;
        #1;
        tests++; if (memWb !== 72'h0) begin fails++; $display("FAIL rstmid_memwb: got %h want 0", memWb); end
        tests++; if (bus.mem_req !== 1'b0 || stall !== 1'b0) begin
            fails++; $display("FAIL rstmid_idle: got req=%b stall=%b want 0/0", bus.mem_req, stall); end
        tick();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_store_zero_wait();
        test_load_wait();
        test_timeout();
        test_misaligned();
        test_back_to_back();
        test_reset_mid_access();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
